axis_image_pattern_src: RTL and testbench



---
 rtl/axis_image_vip_config.sv | 25 ++
 rtl/axis_src_pattern_gen.sv | 37 +++
 rtl/axis_image_pattern_src.sv | 239 +++++++++++++++++++++++
 tb/tb_axis_image_pattern_src.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_image_vip_config.sv
// Shared configuration package for the AXI4-Stream image VIP.
// Holds the source pixel width, the test-pattern selector encoding, the
// pattern source FSM state encoding and the stall LFSR seed.
package axis_image_vip_config;

    // Bytes per pixel beat produced by the pattern source.
    localparam int SOURCE_BYTES = 1;

    // Seed for the optional idle-cycle LFSR in the pattern source.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        PAT_RAMP    = 2'd0,
        PAT_XOR     = 2'd1,
        PAT_FRAME   = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        SRC_IDLE   = 2'd0,
        SRC_STREAM = 2'd1,
        SRC_DONE   = 2'd2
    } src_state_e;

endpackage

// File: rtl/axis_src_pattern_gen.sv
// Combinational pixel function for the image pattern source.
// Ports:
//   pattern_i : pattern selector (pattern_e)
//   x_i, y_i  : pixel column / line
//   f_i       : frame index
//   w_i       : line width in pixels
//   pixel_o   : pixel value, modulo 2^PIXEL_BITS
module axis_src_pattern_gen
    import axis_image_vip_config::*;
#(
    parameter int PIXEL_BITS     = SOURCE_BYTES * 8,
    parameter int X_BITS         = 13,
    parameter int Y_BITS         = 13,
    parameter int FRAME_CNT_BITS = 16
) (
    input  pattern_e                  pattern_i,
    input  logic [X_BITS-1:0]         x_i,
    input  logic [Y_BITS-1:0]         y_i,
    input  logic [FRAME_CNT_BITS-1:0] f_i,
    input  logic [X_BITS-1:0]         w_i,
    output logic [PIXEL_BITS-1:0]     pixel_o
);

    // Every operand is brought to PIXEL_BITS first: the ramp only needs its
    // value modulo 2^PIXEL_BITS, so the full-width product is never built.
    always_comb begin
        pixel_o = '0;
        case (pattern_i)
            PAT_RAMP:    pixel_o = (PIXEL_BITS'(y_i) * PIXEL_BITS'(w_i)) + PIXEL_BITS'(x_i);
            PAT_XOR:     pixel_o = PIXEL_BITS'(x_i) ^ PIXEL_BITS'(y_i);
            PAT_FRAME:   pixel_o = PIXEL_BITS'(f_i);
            PAT_CHECKER: pixel_o = (x_i[3] ^ y_i[3]) ? '1 : '0;
            default:     pixel_o = '0;
        endcase
    end

endmodule

// File: rtl/axis_image_pattern_src.sv
// AXI4-Stream test-pattern image source. Emits num_frames_i frames of
// width_i x height_i pixels, one beat per pixel; tuser marks start of
// frame, tlast marks end of line. num_frames_i == 0 streams forever.
// All outputs are registered; the next beat is precomputed so a beat is
// accepted and replaced in the same cycle.
//
// Optional build macro AXIS_SRC_STALL_EN: a 16-bit LFSR inserts single idle
// cycles after accepted beats (a presented beat is never withdrawn).
//
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   start_i            : begin a run (only honoured in IDLE with nonzero size)
//   width_i, height_i  : frame size, sampled at start
//   num_frames_i       : frames per run, 0 = continuous, sampled at start
//   pattern_i          : pattern_e selector, sampled at start
//   axis_m_*           : AXI4-Stream master (data, valid, ready, last, user)
//   busy_o             : high whenever the FSM is not IDLE
//   done_o             : one-cycle pulse after the final beat is accepted
module axis_image_pattern_src
    import axis_image_vip_config::*;
#(
    parameter int PIXEL_BITS     = SOURCE_BYTES * 8,
    parameter int MAX_W          = 4096,
    parameter int MAX_H          = 4096,
    parameter int FRAME_CNT_BITS = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [$clog2(MAX_W+1)-1:0]    width_i,
    input  logic [$clog2(MAX_H+1)-1:0]    height_i,
    input  logic [FRAME_CNT_BITS-1:0]     num_frames_i,
    input  logic [1:0]                    pattern_i,
    output logic [PIXEL_BITS-1:0]         axis_m_data_o,
    output logic                          axis_m_valid_o,
    input  logic                          axis_m_ready_i,
    output logic                          axis_m_last_o,
    output logic                          axis_m_user_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int XW = $clog2(MAX_W + 1);
    localparam int YW = $clog2(MAX_H + 1);
    localparam int FB = FRAME_CNT_BITS;

    src_state_e           state_q, state_d;
    pattern_e             pat_q, pat_d;
    logic [XW-1:0]        w_q, w_d, x_q, x_d;
    logic [YW-1:0]        h_q, h_d, y_q, y_d;
    logic [FB-1:0]        nf_q, nf_d, f_q, f_d;
    logic                 valid_q, valid_d;
    logic [PIXEL_BITS-1:0] data_q, data_d;
    logic                 last_q, last_d;
    logic                 user_q, user_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Position and pattern of the beat that would be presented next.
    logic                 x_end, y_end;
    logic [XW-1:0]        nx, gen_w;
    logic [YW-1:0]        ny;
    logic [FB-1:0]        nfr;
    pattern_e             gen_pat;
    logic [PIXEL_BITS-1:0] gen_pix;
    logic                 next_user, next_last;
    logic                 accept, last_beat;
    logic                 stall;

`ifdef AXIS_SRC_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length); free-running.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Next-position computation. In IDLE it points at pixel (0,0) of frame 0
    // using the live config inputs, so the first beat is ready on the cycle
    // after start_i.
    always_comb begin
        x_end   = (x_q == w_q - XW'(1));
        y_end   = (y_q == h_q - YW'(1));
        gen_pat = pat_q;
        gen_w   = w_q;
        nx      = x_end ? '0 : x_q + XW'(1);
        ny      = y_q;
        nfr     = f_q;
        if (x_end) begin
            ny = y_end ? '0 : y_q + YW'(1);
            if (y_end) nfr = f_q + FB'(1);  // wraps naturally in continuous mode
        end
        if (state_q == SRC_IDLE) begin
            gen_pat = pattern_e'(pattern_i);
            gen_w   = width_i;
            nx      = '0;
            ny      = '0;
            nfr     = '0;
        end
        next_user = (nx == '0) && (ny == '0);
        next_last = (nx == gen_w - XW'(1));
    end

    axis_src_pattern_gen #(
        .PIXEL_BITS    (PIXEL_BITS),
        .X_BITS        (XW),
        .Y_BITS        (YW),
        .FRAME_CNT_BITS(FB)
    ) u_gen (
        .pattern_i(gen_pat),
        .x_i      (nx),
        .y_i      (ny),
        .f_i      (nfr),
        .w_i      (gen_w),
        .pixel_o  (gen_pix)
    );

    // FSM next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        w_d       = w_q;
        h_d       = h_q;
        nf_d      = nf_q;
        x_d       = x_q;
        y_d       = y_q;
        f_d       = f_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        user_d    = user_q;
        done_d    = 1'b0;
        accept    = valid_q && axis_m_ready_i;
        last_beat = x_end && y_end && (nf_q != '0) && (f_q == nf_q - FB'(1));

        case (state_q)
            SRC_IDLE: begin
                if (start_i && (width_i != '0) && (height_i != '0)) begin
                    state_d = SRC_STREAM;
                    pat_d   = pattern_e'(pattern_i);
                    w_d     = width_i;
                    h_d     = height_i;
                    nf_d    = num_frames_i;
                    x_d     = '0;
                    y_d     = '0;
                    f_d     = '0;
                    valid_d = 1'b1;
                    data_d  = gen_pix;
                    last_d  = next_last;
                    user_d  = next_user;
                end
            end
            SRC_STREAM: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = SRC_DONE;
                        valid_d = 1'b0;
                        data_d  = '0;
                        last_d  = 1'b0;
                        user_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        x_d     = nx;
                        y_d     = ny;
                        f_d     = nfr;
                        data_d  = gen_pix;
                        last_d  = next_last;
                        user_d  = next_user;
                        // An idle cycle may only follow an accepted beat.
                        valid_d = !stall;
                    end
                end else if (!valid_q) begin
                    // Idle cycle over: present the already-loaded beat.
                    valid_d = 1'b1;
                end
            end
            SRC_DONE: begin
                state_d = SRC_IDLE;
            end
            default: begin
                state_d = SRC_IDLE;
            end
        endcase

        busy_d = (state_d != SRC_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SRC_IDLE;
            pat_q   <= PAT_RAMP;
            w_q     <= '0;
            h_q     <= '0;
            nf_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            f_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            w_q     <= w_d;
            h_q     <= h_d;
            nf_q    <= nf_d;
            x_q     <= x_d;
            y_q     <= y_d;
            f_q     <= f_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            user_q  <= user_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign axis_m_data_o  = data_q;
    assign axis_m_valid_o = valid_q;
    assign axis_m_last_o  = last_q;
    assign axis_m_user_o  = user_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_axis_image_pattern_src.sv
`timescale 1ns/1ps
module tb_axis_image_pattern_src;
    import axis_image_vip_config::*;

    localparam int PB = SOURCE_BYTES * 8;
    localparam int XW = $clog2(4096 + 1);
    localparam int YW = $clog2(4096 + 1);
    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [XW-1:0] width = '0;
    logic [YW-1:0] height = '0;
    logic [FB-1:0] nframes = '0;
    logic [1:0]    pattern = '0;
    logic [PB-1:0] data;
    logic          valid;
    logic          ready = 1'b0;
    logic          last;
    logic          user;
    logic          busy;
    logic          done;

    axis_image_pattern_src #(
        .PIXEL_BITS    (PB),
        .MAX_W         (4096),
        .MAX_H         (4096),
        .FRAME_CNT_BITS(FB)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .width_i       (width),
        .height_i      (height),
        .num_frames_i  (nframes),
        .pattern_i     (pattern),
        .axis_m_data_o (data),
        .axis_m_valid_o(valid),
        .axis_m_ready_i(ready),
        .axis_m_last_o (last),
        .axis_m_user_o (user),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PB-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    beat_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt, done_cyc, hold_err, drop_err;
    bit    timed_out;

    // Reference pixel from the pattern definitions, in plain integer math.
    function automatic logic [PB-1:0] ref_pixel(int pat, int x, int y, int f, int w);
        longint v;
        case (pat)
            0:       v = longint'(y) * w + x;
            1:       v = x ^ y;
            2:       v = f;
            default: v = (((x / 8) + (y / 8)) % 2 == 1) ? -1 : 0;
        endcase
        return PB'(v);
    endfunction

    // Expected beat list: frames, then lines, then pixels, in raster order.
    function automatic void build_expected(int w, int h, int nf, int pat, int max_beats);
        int frames;
        beat_t b;
        exp_q.delete();
        frames = (nf == 0) ? (1 << 30) : nf;
        for (int f = 0; f < frames; f++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    if (exp_q.size() >= max_beats) return;
                    b.d = ref_pixel(pat, x, y, f % (1 << FB), w);
                    b.l = (x == w - 1);
                    b.u = (x == 0) && (y == 0);
                    exp_q.push_back(b);
                end
    endfunction

    // One-cycle start pulse; returns at the first negedge after it is taken.
    task automatic start_run(int w, int h, int nf, int pat);
        @(negedge clk);
        width   = XW'(w);
        height  = YW'(h);
        nframes = FB'(nf);
        pattern = 2'(pat);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Drives ready (0: always, 1: 1,0,0 repeating, 2: random) and records
    // accepted beats plus AXIS hold/withdraw events. Stops at done_o
    // (stop_beats == 0) or after stop_beats accepted beats.
    task automatic collect(int mode, int max_cycles, int stop_beats, int poke_cycle);
        bit    prev_v, prev_r;
        beat_t prev_b, cur;
        got_q.delete();
        beat_cyc.delete();
        done_cnt = 0; done_cyc = -1; hold_err = 0; drop_err = 0; timed_out = 1;
        prev_v = 0; prev_r = 0; prev_b = '0;
        for (int c = 0; c < max_cycles; c++) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (c % 3 == 0);
                default: ready = ($urandom % 4) != 0;
            endcase
            start = (c == poke_cycle);
            if (c == poke_cycle) begin
                width = XW'(7); height = YW'(7); pattern = 2'd1;
            end
            cur.d = data; cur.l = last; cur.u = user;
            if (prev_v && !prev_r) begin
                if (!valid) drop_err++;
                else if (cur != prev_b) hold_err++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (valid && ready) begin
                got_q.push_back(cur);
                beat_cyc.push_back(c);
            end
            prev_v = valid; prev_r = ready; prev_b = cur;
            if (stop_beats > 0 && got_q.size() >= stop_beats) begin timed_out = 0; break; end
            if (stop_beats == 0 && done) begin timed_out = 0; break; end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({valid, data, last, user, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b d=%0h l=%0b u=%0b busy=%0b done=%0b, want all 0",
                     valid, data, last, user, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp_basic();
        build_expected(4, 2, 1, 0, 1000);
        start_run(4, 2, 1, 0);
        checks++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ramp_first_valid: got valid=%0b busy=%0b, want 1 1", valid, busy);
        end
        collect(0, 200, 0, -1);
        checks++;
        if (timed_out || got_q.size() != 8) begin
            errors++;
            $display("FAIL ramp_count: got %0d beats (timeout=%0b), want 8", got_q.size(), timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ramp_beat%0d: got d=%0d l=%0b u=%0b, want d=%0d l=%0b u=%0b",
                         i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
`ifndef AXIS_SRC_STALL_EN
        for (int i = 1; i < beat_cyc.size(); i++) begin
            checks++;
            if (beat_cyc[i] != beat_cyc[0] + i) begin
                errors++;
                $display("FAIL ramp_no_bubble%0d: got cycle %0d, want %0d", i, beat_cyc[i], beat_cyc[0] + i);
            end
        end
`endif
        if (beat_cyc.size() > 0) begin
            checks++;
            if (done_cnt != 1 || done_cyc != beat_cyc[beat_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL ramp_done_timing: got count=%0d cycle=%0d, want 1 at %0d",
                         done_cnt, done_cyc, beat_cyc[beat_cyc.size()-1] + 1);
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL ramp_idle_after: got busy=%0b valid=%0b done=%0b, want 0 0 0", busy, valid, done);
        end
    endtask

    task automatic test_backpressure();
        build_expected(4, 2, 1, 0, 1000);
        start_run(4, 2, 1, 0);
        collect(1, 300, 0, 4);
        checks++;
        if (timed_out || got_q.size() != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_count: got %0d beats done=%0d (timeout=%0b), want 8 and 1",
                     got_q.size(), done_cnt, timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got d=%0d l=%0b u=%0b, want d=%0d l=%0b u=%0b",
                         i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
        checks++;
        if (hold_err != 0 || drop_err != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d hold changes and %0d withdrawals, want 0 0", hold_err, drop_err);
        end
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        build_expected(1, 1, 3, 2, 1000);
        start_run(1, 1, 3, 2);
        collect(0, 100, 0, -1);
        checks++;
        if (timed_out || got_q.size() != 3) begin
            errors++;
            $display("FAIL single_count: got %0d beats (timeout=%0b), want 3", got_q.size(), timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_beat%0d: got d=%0d l=%0b u=%0b, want d=%0d l=%0b u=%0b",
                         i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero_dim();
        int bad;
        for (int k = 0; k < 2; k++) begin
            bad = 0;
            if (k == 0) start_run(3, 0, 1, 0);
            else        start_run(0, 5, 1, 0);
            for (int c = 0; c < 8; c++) begin
                if (valid || busy || done) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL zero_dim%0d: got %0d active cycles, want 0", k, bad);
            end
        end
    endtask

    task automatic test_continuous_reset();
        build_expected(2, 2, 0, 2, 20);
        start_run(2, 2, 0, 2);
        collect(0, 200, 20, -1);
        checks++;
        if (timed_out || got_q.size() != 20 || done_cnt != 0) begin
            errors++;
            $display("FAIL cont_count: got %0d beats done=%0d (timeout=%0b), want 20 and 0",
                     got_q.size(), done_cnt, timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL cont_beat%0d: got d=%0d l=%0b u=%0b, want d=%0d l=%0b u=%0b",
                         i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_still_streaming: got valid=%0b busy=%0b, want 1 1", valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid, data, last, user, busy, done} !== '0) begin
            errors++;
            $display("FAIL cont_async_reset: got v=%0b d=%0h l=%0b u=%0b busy=%0b done=%0b, want all 0",
                     valid, data, last, user, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        build_expected(2, 2, 1, 0, 1000);
        start_run(2, 2, 1, 0);
        collect(0, 100, 0, -1);
        checks++;
        if (timed_out || got_q.size() != 4) begin
            errors++;
            $display("FAIL restart_count: got %0d beats (timeout=%0b), want 4", got_q.size(), timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_beat%0d: got d=%0d l=%0b u=%0b, want d=%0d l=%0b u=%0b",
                         i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int w, h, nf, pat, bad;
        for (int it = 0; it < 8; it++) begin
            w   = $urandom_range(1, 20);
            h   = $urandom_range(1, 5);
            nf  = $urandom_range(1, 3);
            pat = $urandom_range(0, 3);
            build_expected(w, h, nf, pat, 100000);
            start_run(w, h, nf, pat);
            collect(2, exp_q.size() * 10 + 50, 0, 2);
            checks++;
            if (timed_out || got_q.size() != exp_q.size() || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_count: W=%0d H=%0d F=%0d P=%0d got %0d beats done=%0d (timeout=%0b), want %0d and 1",
                         it, w, h, nf, pat, got_q.size(), done_cnt, timed_out, exp_q.size());
            end
            bad = -1;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL rand%0d_data: W=%0d H=%0d F=%0d P=%0d beat %0d got d=%0d l=%0b u=%0b, want d=%0d l=%0b u=%0b",
                         it, w, h, nf, pat, bad, got_q[bad].d, got_q[bad].l, got_q[bad].u,
                         exp_q[bad].d, exp_q[bad].l, exp_q[bad].u);
            end
            checks++;
            if (hold_err != 0 || drop_err != 0) begin
                errors++;
                $display("FAIL rand%0d_stable: got %0d hold changes and %0d withdrawals, want 0 0",
                         it, hold_err, drop_err);
            end
            @(negedge clk);
        end
    endtask

`ifdef AXIS_SRC_STALL_EN
    task automatic test_stall();
        build_expected(8, 8, 1, 0, 1000);
        start_run(8, 8, 1, 0);
        collect(0, 1000, 0, -1);
        checks++;
        if (timed_out || got_q.size() != 64) begin
            errors++;
            $display("FAIL stall_count: got %0d beats (timeout=%0b), want 64", got_q.size(), timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_beat%0d: got d=%0d, want d=%0d", i, got_q[i].d, exp_q[i].d);
            end
        end
        checks++;
        if (drop_err != 0 || beat_cyc.size() != 64 || beat_cyc[63] - beat_cyc[0] <= 63) begin
            errors++;
            $display("FAIL stall_gaps: got %0d withdrawals, span %0d, want 0 and span above 63",
                     drop_err, (beat_cyc.size() == 64) ? beat_cyc[63] - beat_cyc[0] : -1);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp_basic();
        test_backpressure();
        test_single_pixel();
        test_zero_dim();
        test_continuous_reset();
        test_random();
`ifdef AXIS_SRC_STALL_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
